// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command driver slice.
package alu_pkg;

    localparam int unsigned OPW = 3;
    localparam int unsigned DW  = 4;
    localparam int unsigned RW  = 5;

    localparam logic [OPW-1:0] OP_PASS = 3'b000;
    localparam logic [OPW-1:0] OP_ADD  = 3'b001;
    localparam logic [OPW-1:0] OP_SUB  = 3'b010;
    localparam logic [OPW-1:0] OP_DIV  = 3'b011;
    localparam logic [OPW-1:0] OP_MOD3 = 3'b100;
    localparam logic [OPW-1:0] OP_SHL  = 3'b101;
    localparam logic [OPW-1:0] OP_SHR  = 3'b110;
    localparam logic [OPW-1:0] OP_GT   = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } cmd_t;

    // True for a divide whose divisor is zero.
    function automatic logic is_div0(input cmd_t c);
        return (c.op == OP_DIV) && (c.b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    cmd_t          mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents are meaningless while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequencer feeding a combinational ALU: queues commands, issues one at a time,
// waits ALU_LAT extra cycles and returns the captured result on a response channel.
// Build option: define DIV0_TRAP_EN to answer divide-by-zero locally with rsp_err=1.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [DW-1:0]  cmd_a,
    input  logic [DW-1:0]  cmd_b,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_select,
    input  logic [RW-1:0]  alu_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [RW-1:0]  rsp_result,
    output logic [OPW-1:0] rsp_op,
    output logic           rsp_err,
    output logic           busy
);

    cmd_t           head;
    cmd_t           wcmd;
    logic           full;
    logic           empty;
    logic           pop;
    logic           trap;
    logic           slot_free;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_sel_q, alu_sel_d;
    logic [OPW-1:0] op_q, op_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [RW-1:0]  rsp_result_q, rsp_result_d;
    logic [OPW-1:0] rsp_op_q, rsp_op_d;
    logic           rsp_err_q, rsp_err_d;

    assign wcmd      = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign cmd_ready = !full;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata (wcmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

`ifdef DIV0_TRAP_EN
    assign trap = is_div0(head);
`else
    assign trap = 1'b0;
`endif

    // The response register is free if empty or being taken this cycle; a finished
    // command waits in StWait until it is, so one command can be in flight behind a
    // stalled response.
    assign slot_free = !rsp_valid_q || rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    if (!trap)         state_d = StWait;
                    else if (slot_free) state_d = StResp;
                end
            end
            StWait: begin
                if ((cnt_q == 4'd0) && slot_free) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values and FIFO pop, decoded from the current state.
    always_comb begin
        pop          = 1'b0;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_err_d    = rsp_err_q;
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    if (!trap) begin
                        pop       = 1'b1;
                        alu_a_d   = head.a;
                        alu_b_d   = head.b;
                        alu_sel_d = head.op;
                        op_d      = head.op;
                        cnt_d     = 4'(ALU_LAT);
                    end else if (slot_free) begin
                        // Trapped divide: never reaches the ALU, alu_* keep old values.
                        pop          = 1'b1;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = '0;
                        rsp_op_d     = head.op;
                        rsp_err_d    = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (slot_free) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_op_d     = op_q;
                    rsp_err_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: directed steps plus random traffic against a response model.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance with ALU_LAT=0
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_select;
    logic [4:0] alu_result;
    logic       rsp_valid, rsp_ready;
    logic [4:0] rsp_result;
    logic [2:0] rsp_op;
    logic       rsp_err, busy;

    // Instance with ALU_LAT=3
    logic       cmd_valid_l, cmd_ready_l;
    logic [2:0] cmd_op_l;
    logic [3:0] cmd_a_l, cmd_b_l;
    logic [3:0] alu_a_l, alu_b_l;
    logic [2:0] alu_select_l;
    logic [4:0] alu_result_l;
    logic       rsp_valid_l, rsp_ready_l;
    logic [4:0] rsp_result_l;
    logic [2:0] rsp_op_l;
    logic       rsp_err_l, busy_l;

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;
    int n_rsp  = 0;
    logic [8:0] exp_q [$];   // {err, op, result}

    // Behavioural ALU: the stub driven into the DUT and the source of expected results.
    function automatic logic [4:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        int ia = int'(a);
        int ib = int'(b);
        int r;
        case (op)
            3'd0:    r = ia;
            3'd1:    r = ia + ib;
            3'd2:    r = ia - ib;
            3'd3:    r = (ib == 0) ? 31 : ia / ib;
            3'd4:    r = ia % 3;
            3'd5:    r = ia * 2;
            3'd6:    r = ia / 2;
            default: r = (ia > ib) ? 1 : 0;
        endcase
        return 5'(r);
    endfunction

    function automatic logic [8:0] rsp_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
`ifdef DIV0_TRAP_EN
        if (op == 3'd3 && b == 4'd0) return {1'b1, op, 5'd0};
`endif
        return {1'b0, op, alu_model(op, a, b)};
    endfunction

    assign alu_result   = alu_model(alu_select, alu_a, alu_b);
    assign alu_result_l = alu_model(alu_select_l, alu_a_l, alu_b_l);

    alu_cmd_driver #(.DEPTH(4), .ALU_LAT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy)
    );

    alu_cmd_driver #(.DEPTH(4), .ALU_LAT(3)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_l), .cmd_ready(cmd_ready_l),
        .cmd_op(cmd_op_l), .cmd_a(cmd_a_l), .cmd_b(cmd_b_l),
        .alu_a(alu_a_l), .alu_b(alu_b_l), .alu_select(alu_select_l),
        .alu_result(alu_result_l),
        .rsp_valid(rsp_valid_l), .rsp_ready(rsp_ready_l), .rsp_result(rsp_result_l),
        .rsp_op(rsp_op_l), .rsp_err(rsp_err_l), .busy(busy_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge with inputs already set: scores the handshakes the
    // next rising edge will perform, then advances to the following falling edge.
    task automatic tick();
        logic [8:0] e;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", 32'(rsp_valid), 0);
            end else begin
                e = exp_q[0];
                check("rsp_result", 32'(rsp_result), 32'(e[4:0]));
                check("rsp_op", 32'(rsp_op), 32'(e[7:5]));
                check("rsp_err", 32'(rsp_err), 32'(e[8]));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    n_rsp++;
                end
            end
        end
        if (cmd_valid && cmd_ready) begin
            exp_q.push_back(rsp_model(cmd_op, cmd_a, cmd_b));
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int start = n_acc;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 50 && n_acc == start; i++) tick();
        cmd_valid = 1'b0;
        check("send_accepted", 32'(n_acc - start), 1);
    endtask

    task automatic drain();
        int budget = 400;
        cmd_valid = 1'b0;
        while ((exp_q.size() != 0 || busy) && budget > 0) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            budget--;
        end
        check("drain_left", 32'(exp_q.size()), 0);
        check("drain_busy", 32'(busy), 0);
    endtask

    initial begin
        int start;
        int seen;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        cmd_valid_l = 1'b0; cmd_op_l = '0; cmd_a_l = '0; cmd_b_l = '0; rsp_ready_l = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_alu", 32'({alu_a, alu_b, alu_select}), 0);
        check("rst_rsp", 32'({rsp_result, rsp_op, rsp_err}), 0);
        rst_n = 1'b1;
        tick();

        // Add 9+3 with latency checks
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 4'd9; cmd_b = 4'd3;
        tick();
        cmd_valid = 1'b0;
        check("lat_t0_valid", 32'(rsp_valid), 0);
        tick();
        check("lat_t1_issue", 32'({alu_select, alu_a, alu_b}), 32'({3'd1, 4'd9, 4'd3}));
        check("lat_t1_valid", 32'(rsp_valid), 0);
        tick();
        check("lat_t2_valid", 32'(rsp_valid), 1);
        check("add_result", 32'(rsp_result), 12);
        tick();
        check("lat_t3_valid", 32'(rsp_valid), 0);
        check("lat_t3_busy", 32'(busy), 0);

        // Sub wrap and shift left
        send(3'd2, 4'd3, 4'd5);
        send(3'd5, 4'd15, 4'd0);
        drain();

        // Backpressure: capacity is 4 queued + 1 in flight + 1 held
        rsp_ready = 1'b0;
        start = n_acc;
        cmd_valid = 1'b1;
        cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        for (int i = 0; i < 20; i++) begin
            int prev = n_acc;
            tick();
            if (n_acc != prev) begin
                cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
            end
        end
        check("bp_accepted", 32'(n_acc - start), 6);
        check("bp_cmd_ready", 32'(cmd_ready), 0);
        start = n_rsp;
        drain();
        check("bp_responses", 32'(n_rsp - start), 6);

        // Divide by zero, preceded by a known issued command
        send(3'd5, 4'd15, 4'd1);
        drain();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 4'd7; cmd_b = 4'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
`ifdef DIV0_TRAP_EN
        check("div0_t1_valid", 32'(rsp_valid), 1);
        tick();
        check("div0_alu_select", 32'(alu_select), 5);
`else
        check("div0_t1_valid", 32'(rsp_valid), 0);
        tick();
        check("div0_alu_select", 32'(alu_select), 3);
`endif
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 1) != 0);
            cmd_op = 3'($urandom);
            cmd_a = 4'($urandom);
            cmd_b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();

        // ALU_LAT=3: gt 7>2, operands held for 4 cycles before sampling
        rsp_ready_l = 1'b1;
        cmd_valid_l = 1'b1; cmd_op_l = 3'd7; cmd_a_l = 4'd7; cmd_b_l = 4'd2;
        check("l_cmd_ready", 32'(cmd_ready_l), 1);
        tick();
        cmd_valid_l = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("l_alu_stable", 32'({alu_select_l, alu_a_l, alu_b_l}),
                  32'({3'd7, 4'd7, 4'd2}));
            check("l_wait_valid", 32'(rsp_valid_l), 0);
        end
        tick();
        check("l_rsp_valid", 32'(rsp_valid_l), 1);
        check("l_rsp_result", 32'(rsp_result_l), 32'(alu_model(3'd7, 4'd7, 4'd2)));
        tick();
        check("l_rsp_done", 32'(rsp_valid_l), 0);

        // Reset while a command waits and three are queued
        cmd_valid_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_op_l = 3'($urandom); cmd_a_l = 4'($urandom); cmd_b_l = 4'($urandom | 1);
            tick();
        end
        cmd_valid_l = 1'b0;
        check("rw_busy_before", 32'(busy_l), 1);
        check("rw_full_before", 32'(rsp_valid_l), 0);
        #2 rst_n = 1'b0;
        #1;
        check("rw_cmd_ready", 32'(cmd_ready_l), 1);
        check("rw_rsp_valid", 32'(rsp_valid_l), 0);
        check("rw_busy", 32'(busy_l), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (rsp_valid_l) seen++;
            tick();
        end
        check("rw_no_stale_rsp", 32'(seen), 0);
        check("rw_idle_after", 32'(busy_l), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
